// File: rtl/nios_pio_in_irq.sv
// -----------------------------------------------------------------------------
// nios_pio_in_irq
//
// Parametrised Avalon-MM input PIO slave with edge capture and a level
// interrupt. External inputs pass through a 2-flop synchroniser (and an
// optional per-bit debounce filter) before being presented on the data
// register and fed to the edge detector.
//
// Optional feature macro: PIO_IN_DEBOUNCE_EN
//   defined   -> per-bit 16-bit debounce counters filter the synchronised input
//   undefined -> the synchronised input is used directly, DEBOUNCE_CYCLES unused
//
// Ports:
//   clk        in   1      system clock
//   reset_n    in   1      asynchronous active-low reset
//   address    in   2      Avalon word address (0 data, 1 mask, 2 capture, 3 rsvd)
//   chipselect in   1      slave select (qualifies writes only)
//   write_n    in   1      active-low write strobe
//   writedata  in   32     write data
//   in_port    in   WIDTH  asynchronous external inputs
//   readdata   out  32     registered read data, read latency 1
//   irq        out  1      level interrupt, active high
// -----------------------------------------------------------------------------
module nios_pio_in_irq #(
    parameter int               WIDTH           = 8,
    parameter int               EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] RESET_MASK      = {WIDTH{1'b0}},
    parameter int               DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] EDGE_SEL = 2'(EDGE_TYPE);

    logic [WIDTH-1:0] sync0_r;
    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] val_s;
    logic [WIDTH-1:0] prev_r;
    logic [WIDTH-1:0] edge_s;
    logic [WIDTH-1:0] edge_capture_r;
    logic [WIDTH-1:0] edge_capture_next_s;
    logic [WIDTH-1:0] irq_mask_r;
    logic [WIDTH-1:0] clear_s;
    logic [WIDTH-1:0] set_s;
    logic [1:0]       arm_r;
    logic [31:0]      readdata_r;
    logic [31:0]      read_mux_s;
    logic             wr_en_s;
    logic             armed_s;
    logic             unused_s;

    // Bits of writedata above WIDTH carry no meaning for this port
    assign unused_s = ^(writedata >> WIDTH);

    assign wr_en_s = chipselect & ~write_n;
    assign armed_s = (arm_r == 2'd3);

    // Two-flop synchroniser for the asynchronous board inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0_r <= {WIDTH{1'b0}};
            sync1_r <= {WIDTH{1'b0}};
        end else begin
            sync0_r <= in_port;
            sync1_r <= sync0_r;
        end
    end

`ifdef PIO_IN_DEBOUNCE_EN
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0]      db_cnt_r [WIDTH];
    logic [WIDTH-1:0] val_r;

    // Debounce: a bit only changes after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            val_r <= {WIDTH{1'b0}};
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt_r[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync1_r[i] != val_r[i]) begin
                    if (db_cnt_r[i] == DB_LAST) begin
                        val_r[i]    <= sync1_r[i];
                        db_cnt_r[i] <= 16'd0;
                    end else begin
                        db_cnt_r[i] <= db_cnt_r[i] + 16'd1;
                    end
                end else begin
                    db_cnt_r[i] <= 16'd0;
                end
            end
        end
    end

    assign val_s = val_r;
`else
    assign val_s = sync1_r;
`endif

    // Previous filtered value for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_r <= {WIDTH{1'b0}};
        end else begin
            prev_r <= val_s;
        end
    end

    // Edge detector selected by EDGE_TYPE; unknown codes fall back to rising
    always_comb begin
        edge_s = {WIDTH{1'b0}};
        case (EDGE_SEL)
            2'd0:    edge_s = val_s & ~prev_r;
            2'd1:    edge_s = ~val_s & prev_r;
            2'd2:    edge_s = val_s ^ prev_r;
            default: edge_s = val_s & ~prev_r;
        endcase
    end

    // Arm counter: capture is held off for three clocks after reset release so
    // inputs already active at power-up are not reported as edges
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_r <= 2'd0;
        end else if (!armed_s) begin
            arm_r <= arm_r + 2'd1;
        end else begin
            arm_r <= arm_r;
        end
    end

    // Next capture value: write-1-to-clear first, then new edges, so a set wins
    always_comb begin
        clear_s = {WIDTH{1'b0}};
        set_s   = {WIDTH{1'b0}};
        if (wr_en_s && (address == 2'd2)) begin
            clear_s = writedata[WIDTH-1:0];
        end else begin
            clear_s = {WIDTH{1'b0}};
        end
        if (armed_s) begin
            set_s = edge_s;
        end else begin
            set_s = {WIDTH{1'b0}};
        end
        edge_capture_next_s = (edge_capture_r & ~clear_s) | set_s;
    end

    // Edge capture register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture_r <= {WIDTH{1'b0}};
        end else begin
            edge_capture_r <= edge_capture_next_s;
        end
    end

    // Interrupt mask register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_r <= RESET_MASK;
        end else if (wr_en_s && (address == 2'd1)) begin
            irq_mask_r <= writedata[WIDTH-1:0];
        end else begin
            irq_mask_r <= irq_mask_r;
        end
    end

    // Read mux; reads need no chipselect and unused upper bits read as zero
    always_comb begin
        read_mux_s = 32'd0;
        case (address)
            2'd0:    read_mux_s[WIDTH-1:0] = val_s;
            2'd1:    read_mux_s[WIDTH-1:0] = irq_mask_r;
            2'd2:    read_mux_s[WIDTH-1:0] = edge_capture_r;
            default: read_mux_s = 32'd0;
        endcase
    end

    // Registered read data, one cycle of latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_r <= 32'd0;
        end else begin
            readdata_r <= read_mux_s;
        end
    end

    assign readdata = readdata_r;
    assign irq      = |(edge_capture_r & irq_mask_r);

endmodule
